// File: rtl/kryptering_pkg.sv
// Shared definitions for the kryptering encryptor/decryptor pair.
// The cipher helpers live here so both directions use one implementation.
package kryptering_pkg;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    KEYLO = 2'd1,
    RUN   = 2'd2
  } krypt_state_e;

  localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;
  localparam logic [15:0] ZERO_SEED_DEFAULT = 16'hACE1;
  localparam logic [2:0]  ROT_DEFAULT       = 3'd3;

  // Debug view of the decryptor: FSM state plus keystream registers.
  typedef struct packed {
    krypt_state_e state;
    logic [15:0]  lfsr;
    logic [7:0]   ctr;
  } kryptering_dbg_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] amt);
    logic [15:0] d;
    d = {x, x} << amt;
    return d[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] amt);
    logic [15:0] d;
    d = {x, x} >> amt;
    return d[7:0];
  endfunction

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l, input logic [15:0] taps);
    return (l >> 1) ^ (l[0] ? taps : 16'h0000);
  endfunction

endpackage

// File: rtl/kryptering_keystream.sv
// Keystream generator: 16-bit Galois LFSR plus 8-bit byte counter.
// seed_load restarts the stream (counter to 0); advance steps both by one byte.
module kryptering_keystream import kryptering_pkg::*; #(
  parameter logic [15:0] LFSR_TAPS = LFSR_TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load_i,
  input  logic [15:0] seed_i,
  input  logic        advance_i,
  output logic [7:0]  ks_o,
  output logic [7:0]  ctr_o,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  ctr_q, ctr_d;

  // Next keystream state: reseed wins over advance.
  always_comb begin
    lfsr_d = lfsr_q;
    ctr_d  = ctr_q;
    if (seed_load_i) begin
      lfsr_d = seed_i;
      ctr_d  = 8'd0;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q, LFSR_TAPS);
      ctr_d  = ctr_q + 8'd1;
    end
  end

  // Keystream registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'h0000;
      ctr_q  <= 8'd0;
    end else begin
      lfsr_q <= lfsr_d;
      ctr_q  <= ctr_d;
    end
  end

  assign ks_o   = lfsr_q[7:0];
  assign ctr_o  = ctr_q;
  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/kryptering_decryptor.sv
// Byte-serial stream decryptor: P = rotr(C - ctr, ROT) ^ ks.
// Handshake: a byte moves across an interface on every rising edge where
// valid and ready are both 1; valid, once raised, holds its data stable
// until that transfer, and in_ready never depends on in_valid.
module kryptering_decryptor import kryptering_pkg::*; #(
  parameter logic [15:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
  parameter logic [15:0] ZERO_SEED = ZERO_SEED_DEFAULT,
  parameter logic [2:0]  ROT       = ROT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_load,
  input  logic [7:0]      key_byte,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  output logic            keyed,
  output kryptering_dbg_t dbg
);

  krypt_state_e state_q, state_d;
  logic [7:0]   key_hi_q, key_hi_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   out_data_q, out_data_d;

  logic         seed_load;
  logic [15:0]  seed_val;
  logic         accept;
  logic [7:0]   ks;
  logic [7:0]   ctr;
  logic [15:0]  lfsr;
  logic [7:0]   t;

  kryptering_keystream #(
    .LFSR_TAPS (LFSR_TAPS)
  ) u_ks (
    .clk         (clk),
    .rst         (rst),
    .seed_load_i (seed_load),
    .seed_i      (seed_val),
    .advance_i   (accept),
    .ks_o        (ks),
    .ctr_o       (ctr),
    .lfsr_o      (lfsr)
  );

  // Input is blocked while keying, during a key strobe, and while output stalls.
  assign in_ready = (state_q == RUN) && !key_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign t        = in_data - ctr;

  // Key-loading FSM: two key bytes (high first) take us to RUN; an all-zero
  // key is replaced so the LFSR never locks up.
  always_comb begin
    state_d   = state_q;
    key_hi_d  = key_hi_q;
    seed_load = 1'b0;
    seed_val  = {key_hi_q, key_byte};
    if (seed_val == 16'h0000) seed_val = ZERO_SEED;
    case (state_q)
      NOKEY, RUN: begin
        if (key_load) begin
          key_hi_d = key_byte;
          state_d  = KEYLO;
        end
      end
      KEYLO: begin
        if (key_load) begin
          seed_load = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = NOKEY;
    endcase
  end

  // Output register: a new byte replaces the old one, otherwise drain clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = rotr8(t, ROT) ^ ks;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State, key and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= NOKEY;
      key_hi_q    <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      key_hi_q    <= key_hi_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign keyed     = (state_q == RUN);

  assign dbg.state = state_q;
  assign dbg.lfsr  = lfsr;
  assign dbg.ctr   = ctr;

endmodule

// File: tb/tb_kryptering_decryptor.sv
// Directed bench for kryptering_decryptor with hand-computed vectors and a
// small encryptor model for the long counter-wrap run.
module tb_kryptering_decryptor;
  import kryptering_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            key_load = 1'b0;
  logic [7:0]      key_byte = 8'd0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data  = 8'd0;
  logic            in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_ready = 1'b1;
  logic            keyed;
  kryptering_dbg_t dbg;

  kryptering_decryptor dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_byte  (key_byte),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .keyed     (keyed),
    .dbg       (dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] hi, input logic [7:0] lo);
    key_load = 1'b1; key_byte = hi;
    tick();
    key_byte = lo;
    tick();
    key_load = 1'b0;
  endtask

  // ---------------- reference encryptor model ----------------
  function automatic logic [7:0] m_rotl3(input logic [7:0] x);
    return {x[4:0], x[7:5]};
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  logic [15:0] m_lfsr;
  logic [7:0]  m_ctr;
  logic [7:0]  p;

  initial begin
    // ---- reset state ----
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_keyed", keyed, 0);
    chk("rst_state", dbg.state, NOKEY);
    chk("rst_lfsr", dbg.lfsr, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // ---- ungated input: no key ----
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("nokey_in_ready", in_ready, 0);
    tick(); tick();
    chk("nokey_out_valid", out_valid, 0);
    // only the high key byte loaded
    in_valid = 1'b0;
    key_load = 1'b1; key_byte = 8'h00;
    tick();
    key_load = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("keylo_state", dbg.state, KEYLO);
    chk("keylo_in_ready", in_ready, 0);
    chk("keylo_keyed", keyed, 0);
    tick(); tick();
    chk("keylo_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // ---- keyed decode: key 0x0001 ----
    key_load = 1'b1; key_byte = 8'h01;
    tick();
    key_load = 1'b0;
    chk("kd_keyed", keyed, 1);
    chk("kd_seed", dbg.lfsr, 16'h0001);
    chk("kd_ctr0", dbg.ctr, 0);
    in_valid = 1'b1; in_data = 8'h00;
    #1;
    chk("kd_in_ready", in_ready, 1);
    tick();
    chk("kd_v0", out_valid, 1);
    chk("kd_d0", out_data, 8'h01);
    chk("kd_lfsr1", dbg.lfsr, 16'hB400);
    in_data = 8'h09;
    tick();
    chk("kd_d1", out_data, 8'h01);
    chk("kd_lfsr2", dbg.lfsr, 16'h5A00);
    in_data = 8'h02;
    tick();
    chk("kd_d2", out_data, 8'h00);
    chk("kd_ctr3", dbg.ctr, 3);
    in_valid = 1'b0;
    tick();
    chk("kd_drain", out_valid, 0);

    // ---- backpressure: lfsr 0x2D00, ctr 3 ----
    in_valid = 1'b1; in_data = 8'h0B;   // t=0x08 -> rotr 0x01 -> ^0x00
    tick();
    chk("bp_d0", out_data, 8'h01);
    out_ready = 1'b0; in_data = 8'h04; // next byte: ctr 4, ks 0x80 -> 0x80
    #1;
    chk("bp_in_ready", in_ready, 0);
    tick(); tick(); tick();
    chk("bp_hold_v", out_valid, 1);
    chk("bp_hold_d", out_data, 8'h01);
    chk("bp_lfsr", dbg.lfsr, 16'h1680);
    chk("bp_ctr", dbg.ctr, 4);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    tick();
    chk("bp_d1", out_data, 8'h80);
    chk("bp_lfsr2", dbg.lfsr, 16'h0B40);
    chk("bp_ctr2", dbg.ctr, 5);

    // ---- rekey with pending output; zero key -> 0xACE1 ----
    in_data = 8'h05;                    // ctr 5, ks 0x40 -> 0x40
    tick();
    chk("rk_pend", out_data, 8'h40);
    in_valid = 1'b1; out_ready = 1'b0;
    key_load = 1'b1; key_byte = 8'h00;
    #1;
    chk("rk_in_ready_kl", in_ready, 0);
    tick();
    chk("rk_state", dbg.state, KEYLO);
    chk("rk_held_v", out_valid, 1);
    chk("rk_held_d", out_data, 8'h40);
    key_byte = 8'h00;                   // second byte, output still stalled
    #1;
    chk("rk_in_ready_kl2", in_ready, 0);
    tick();
    key_load = 1'b0;
    chk("rk_keyed", keyed, 1);
    chk("rk_zero_seed", dbg.lfsr, 16'hACE1);
    chk("rk_ctr0", dbg.ctr, 0);
    chk("rk_still_v", out_valid, 1);
    chk("rk_still_d", out_data, 8'h40);
    in_data = 8'h00; out_ready = 1'b1;
    #1;
    chk("rk_acc_drain_rdy", in_ready, 1);
    tick();
    chk("zk_v", out_valid, 1);
    chk("zk_d", out_data, 8'hE1);
    chk("zk_lfsr", dbg.lfsr, 16'hE270);
    in_valid = 1'b0;
    tick();
    chk("zk_drain", out_valid, 0);

    // ---- counter wrap: 257 bytes against the encryptor model ----
    load_key(8'h12, 8'h34);
    m_lfsr = 16'h1234;
    m_ctr  = 8'd0;
    for (int i = 0; i < 257; i++) begin
      p = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = m_rotl3(p ^ m_lfsr[7:0]) + m_ctr;
      tick();
      chk("wrap_pt", out_data, p);
      m_lfsr = m_step(m_lfsr);
      m_ctr  = m_ctr + 8'd1;
      if (i == 255) chk("wrap_ctr0", dbg.ctr, 0);
      if (i == 256) chk("wrap_lfsr", dbg.lfsr, m_lfsr);
    end

    // ---- reset mid-cycle with pending output ----
    chk("mr_pre_v", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_keyed", keyed, 0);
    chk("mr_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("mr_post_state", dbg.state, NOKEY);
    chk("mr_post_v", out_valid, 0);
    chk("mr_post_rdy", in_ready, 0);
    in_valid = 1'b0;

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
